// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch-decode-execute unit and its instruction feeder.
// Instruction layout: mode[7] | opcode[6:4] | regA[3:2] | regB[1:0].
package cpu_isa_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } feeder_state_t;

  localparam int MODE_BIT  = 7;
  localparam int OPCODE_HI = 6;
  localparam int OPCODE_LO = 4;
  localparam int REGA_HI   = 3;
  localparam int REGA_LO   = 2;
  localparam int REGB_HI   = 1;
  localparam int REGB_LO   = 0;

  localparam logic [2:0] ADD     = 3'b001;
  localparam logic [2:0] INC     = 3'b011;
  localparam logic [2:0] HALT_OP = 3'b111;

  function automatic logic is_halt(input logic [7:0] instr);
    return (instr[MODE_BIT] == 1'b0) && (instr[OPCODE_HI:OPCODE_LO] == HALT_OP);
  endfunction

endpackage

// File: rtl/instr_feeder_prog_ram.sv
// Program memory: DEPTH x INSTR_W, one synchronous write port and one
// synchronous read port whose output register holds until the next read.
module prog_ram #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clock_pulse,
  input  logic               wr_en,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clock_pulse) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/instr_feeder.sv
// Instruction feeder: loads a program from board I/O, then serves one word per fetch.
// Build option INSTR_FEEDER_LOOP_EN: end of program wraps to address 0 instead of halting.
module instr_feeder
  import cpu_isa_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 8
) (
  input  logic               clock_pulse,
  input  logic               resetn,
  input  logic               clear,
  input  logic               start,
  input  logic               wr_strobe,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               fetch_req,
  output logic [INSTR_W-1:0] instr_out,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    prog_len,
  output logic               full,
  output logic               running,
  output logic               done
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  feeder_state_t      state, state_nxt;
  logic [ADDR_W-1:0]  pc_r, pc_nxt;
  logic [ADDR_W:0]    len_r, len_nxt;
  logic               wr_en, rd_en;
  logic               full_w, last_word, halt_seen;
  logic               vld_p1, issued_p1;
  logic [INSTR_W-1:0] ram_q_p1;

  assign full_w    = (len_r == LEN_MAX);
  assign last_word = ({1'b0, pc_r} == (len_r - 1'b1));
  // A HALT word is only visible once it leaves the RAM, so it stops the
  // block the cycle after it is delivered and blocks any fetch in that cycle.
  assign halt_seen = vld_p1 && is_halt(ram_q_p1);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_r;
    len_nxt   = len_r;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    if (clear) begin
      state_nxt = LOAD;
      pc_nxt    = '0;
      len_nxt   = '0;
    end else begin
      case (state)
        LOAD: begin
          if (wr_strobe && !full_w) begin
            wr_en   = 1'b1;
            len_nxt = len_r + 1'b1;
          end
          if (start && (len_nxt != '0)) begin
            state_nxt = RUN;
            pc_nxt    = '0;
          end
        end
        RUN: begin
          if (halt_seen) begin
            state_nxt = HALT;
          end else if (fetch_req) begin
            rd_en  = 1'b1;
            pc_nxt = pc_r + 1'b1;
            if (last_word) begin
`ifdef INSTR_FEEDER_LOOP_EN
              pc_nxt = '0;
`else
              state_nxt = HALT;
`endif
            end
          end
        end
        HALT: begin
          if (start) begin
            state_nxt = RUN;
            pc_nxt    = '0;
          end
        end
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      state     <= LOAD;
      pc_r      <= '0;
      len_r     <= '0;
      vld_p1    <= 1'b0;
      issued_p1 <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_r   <= pc_nxt;
      len_r  <= len_nxt;
      vld_p1 <= rd_en;
      if (rd_en) issued_p1 <= 1'b1;
    end
  end

  // ---- stage p1: RAM output register, one cycle after the accepted fetch ----
  prog_ram #(
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_prog_ram (
    .clock_pulse (clock_pulse),
    .wr_en       (wr_en),
    .wr_addr     (len_r[ADDR_W-1:0]),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_addr     (pc_r),
    .rd_data     (ram_q_p1)
  );

  assign instr_out   = issued_p1 ? ram_q_p1 : '0;
  assign instr_valid = vld_p1;
  assign pc          = pc_r;
  assign prog_len    = len_r;
  assign full        = full_w;
  assign running     = (state == RUN);
  assign done        = (state == HALT);

endmodule

// File: doc/instr_feeder.md
Name: instr_feeder

Overview:
- Instruction source for the fetch-decode-execute control unit. It replaces direct switch entry with a small program memory.
- Program load: the user writes a sequence of 8-bit instructions (mode/opcode/regA/regB format) into the memory.
- Program serve: the block answers one fetch request per cycle with the next instruction.
- Halt: it stops on a HALT encoding or at the end of the program.
- It sits between the board I/O (switches/keys) and the control unit's fetch stage.

Parameters:
- DEPTH, 16, number of instruction words in program memory (power of two).
- ADDR_W, 4, log2(DEPTH); width of pc.
- INSTR_W, 8, instruction width.

Ports:
- clock_pulse  in  1  clock; all state changes on posedge.
- resetn  in  1  reset, asynchronous, active-low.
- clear  in  1  pulse: return to LOAD, empty the program.
- start  in  1  pulse: begin serving from address 0.
- wr_strobe  in  1  pulse: append wr_data to the program (LOAD only).
- wr_data  in  INSTR_W  instruction word to append.
- fetch_req  in  1  control unit requests the next instruction (sampled each posedge).
- instr_out  out  INSTR_W  last issued instruction; held between responses.
- instr_valid  out  1  one-cycle pulse: instr_out is new this cycle.
- pc  out  ADDR_W  address of the next instruction to issue.
- prog_len  out  ADDR_W+1  number of words loaded (0..DEPTH).
- full  out  1  prog_len == DEPTH.
- running  out  1  state == RUN.
- done  out  1  state == HALT.

Behaviour:
- Reset: state=LOAD, pc=0, wr_ptr/prog_len=0, instr_out=0, instr_valid=0, full=0, running=0, done=0. Memory contents are not reset.
- States:
  - LOAD: wr_strobe with !full writes mem[prog_len]<=wr_data, then prog_len+1. wr_strobe while full is ignored; nothing changes.
  - LOAD, start with prog_len>0: go to RUN next cycle, pc=0. start with prog_len==0 is ignored.
  - LOAD, wr_strobe and start in the same cycle: the write completes, the new word counts in prog_len, and the program enters RUN.
  - RUN, fetch_req high at posedge: next cycle instr_out=mem[pc], instr_valid=1 (latency 1), pc increments.
  - RUN, fetch_req low: instr_valid=0 and instr_out holds.
  - RUN, back-to-back: fetch_req held high yields one instruction per cycle.
  - RUN end condition: after issuing word pc==prog_len-1, OR after issuing HALT (mode=0, opcode=3'b111, any reg bits), go to HALT. That last word is still delivered with instr_valid=1.
  - HALT: fetch_req is ignored, instr_valid=0, instr_out holds the last word.
  - HALT, start: go to RUN, pc=0; the program is retained.
- clear in any state: go to LOAD next cycle, prog_len=0, pc=0, instr_valid=0. clear has priority over start, wr_strobe and fetch_req in the same cycle.
- wr_strobe outside LOAD is ignored. start in RUN is ignored.
- pc arithmetic is modulo DEPTH. prog_len saturates at DEPTH.
- Reset asserted mid-RUN: all outputs return to reset values immediately (async); no partial response.

Optional Feature:
- Macro: INSTR_FEEDER_LOOP_EN.
- Defined: reaching the end of the program wraps pc to 0 and stays in RUN, so the program loops continuously. The HALT encoding still stops the block.
- Not defined: end of program goes to HALT as above.

Decomposition:
- Shared package cpu_isa_pkg holds:
  - state encoding typedef feeder_state_t {LOAD, RUN, HALT};
  - instruction field slices (MODE bit 7, OPCODE [6:4], REGA [3:2], REGB [1:0]);
  - opcode constants ADD=3'b001, INC=3'b011, HALT_OP=3'b111. The control unit reuses these.
- One natural sub-module, prog_ram: DEPTH x INSTR_W, one synchronous write port, one synchronous read port.

Test Plan:
- Load 8'h14, 8'h31, 8'h14; pulse start; hold fetch_req 3 cycles:
  - instr_valid high in 3 consecutive cycles, starting 1 cycle after the first req, with instr_out 14,31,14;
  - then done=1, pc=3.
- Load 8'h31, 8'h70, 8'h14; start; fetch 3 times:
  - only 31 and 70 are issued, then done=1;
  - the third req gives no instr_valid.
- Write 17 words with DEPTH=16:
  - full=1 after the 16th write; prog_len=16; the 17th write does not change mem[0..15].
- Mid-RUN (pc=2): assert clear and fetch_req in the same cycle:
  - next cycle state=LOAD, prog_len=0, instr_valid=0.
- start with prog_len=0: stays in LOAD, running=0.
- LOOP_EN build, 2-word program {8'h31, 8'h14}, fetch 5 times:
  - instr_out sequence 31,14,31,14,31; done stays 0.
